// File: rtl/pcie_iop2_pkg.sv
// Shared IOP2 message field positions and pack/unpack helpers.
// The message arbiter and every IOP2 endpoint use this package.
package pcie_iop2_pkg;

    localparam int IOP2_MSG_W    = 64;
    localparam int IOP2_ADDR_W   = 20;
    localparam int IOP2_DATA_W   = 32;

    localparam int IOP2_RD_RESP  = 63;
    localparam int IOP2_WR_REQ   = 62;
    localparam int IOP2_RD_REQ   = 61;
    localparam int IOP2_HALF     = 60;
    localparam int IOP2_RSVD_MSB = 59;
    localparam int IOP2_RSVD_LSB = 52;
    localparam int IOP2_ADDR_MSB = 51;
    localparam int IOP2_ADDR_LSB = 32;
    localparam int IOP2_DATA_MSB = 31;
    localparam int IOP2_DATA_LSB = 0;

    typedef struct packed {
        logic                   rdResp;
        logic                   wrReq;
        logic                   rdReq;
        logic                   half;
        logic [7:0]             rsvd;
        logic [IOP2_ADDR_W-1:0] addr;
        logic [IOP2_DATA_W-1:0] data;
    } iop2_msg_t;

    function automatic iop2_msg_t iop2_unpack(input logic [IOP2_MSG_W-1:0] raw);
        iop2_msg_t m;
        m.rdResp = raw[IOP2_RD_RESP];
        m.wrReq  = raw[IOP2_WR_REQ];
        m.rdReq  = raw[IOP2_RD_REQ];
        m.half   = raw[IOP2_HALF];
        m.rsvd   = raw[IOP2_RSVD_MSB:IOP2_RSVD_LSB];
        m.addr   = raw[IOP2_ADDR_MSB:IOP2_ADDR_LSB];
        m.data   = raw[IOP2_DATA_MSB:IOP2_DATA_LSB];
        return m;
    endfunction

    function automatic logic [IOP2_MSG_W-1:0] iop2_pack(input iop2_msg_t m);
        logic [IOP2_MSG_W-1:0] raw;
        raw                               = '0;
        raw[IOP2_RD_RESP]                 = m.rdResp;
        raw[IOP2_WR_REQ]                  = m.wrReq;
        raw[IOP2_RD_REQ]                  = m.rdReq;
        raw[IOP2_HALF]                    = m.half;
        raw[IOP2_RSVD_MSB:IOP2_RSVD_LSB]  = m.rsvd;
        raw[IOP2_ADDR_MSB:IOP2_ADDR_LSB]  = m.addr;
        raw[IOP2_DATA_MSB:IOP2_DATA_LSB]  = m.data;
        return raw;
    endfunction

endpackage

// File: rtl/pcie_iop2_rd_timer.sv
// Read-ack watchdog: loads TIMEOUT, counts down while enabled, flags expiry at zero.
// Only instantiated when IOP2_REGPORT_TIMEOUT_EN is defined.
module pcie_iop2_rd_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT);

    logic [CW-1:0] count_q;

    // Counter saturates at zero so expiry stays asserted until the next load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= LOAD_VAL;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/pcie_iop2_msg_regport.sv
// IOP2 message endpoint bridging arbiter register messages to a strobe-based register port.
// Optional read timeout enabled by defining IOP2_REGPORT_TIMEOUT_EN.
module pcie_iop2_msg_regport
    import pcie_iop2_pkg::*;
#(
    parameter int          ADDR_W       = 8,
    parameter int          TIMEOUT      = 1023,
    parameter logic [31:0] TIMEOUT_DATA = 32'hBADC0FFE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IOP2_MSG_W-1:0] regi_tdata,
    input  logic                  regi_tvalid,
    output logic                  regi_tready,
    output logic [IOP2_MSG_W-1:0] rego_tdata,
    output logic                  rego_tvalid,
    input  logic                  rego_tready,
    output logic                  reg_wr_stb,
    output logic                  reg_rd_stb,
    output logic [ADDR_W-1:0]     reg_addr,
    output logic [31:0]           reg_wr_data,
    output logic                  reg_half,
    input  logic                  reg_rd_ack,
    input  logic [31:0]           reg_rd_data
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [IOP2_ADDR_W-1:0] addr_q;
    logic [31:0]            wrData_q;
    logic [31:0]            rdData_q;
    logic                   half_q;
    logic                   rdFirst_q;

    iop2_msg_t reqMsg;
    iop2_msg_t respMsg;
    logic      accept;
    logic      readStart;
    logic      rdTimeout;
    logic      unusedBits;

    assign reqMsg    = iop2_unpack(regi_tdata);
    assign accept    = (state_q == IDLE) && regi_tvalid;
    assign readStart = accept && !reqMsg.wrReq && reqMsg.rdReq;

    // Write wins over read when both request bits are set; anything else is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (regi_tvalid) begin
                    if (reqMsg.wrReq) begin
                        state_d = WRITE;
                    end else if (reqMsg.rdReq) begin
                        state_d = READ;
                    end
                end
            end
            WRITE: state_d = IDLE;
            READ: begin
                if (reg_rd_ack || rdTimeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rego_tready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            wrData_q  <= '0;
            rdData_q  <= '0;
            half_q    <= 1'b0;
            rdFirst_q <= 1'b0;
        end else begin
            rdFirst_q <= readStart;
            if (accept) begin
                addr_q   <= reqMsg.addr;
                wrData_q <= reqMsg.data;
                half_q   <= reqMsg.half;
            end
            if (state_q == READ) begin
                if (reg_rd_ack) begin
                    rdData_q <= reg_rd_data;
                end else if (rdTimeout) begin
                    rdData_q <= TIMEOUT_DATA;
                end
            end
        end
    end

`ifdef IOP2_REGPORT_TIMEOUT_EN
    logic timerExpired;

    pcie_iop2_rd_timer #(
        .TIMEOUT (TIMEOUT)
    ) uRdTimer (
        .clk_i     (clk),
        .rst_i     (reset),
        .load_i    (readStart),
        .en_i      (state_q == READ),
        .expired_o (timerExpired)
    );

    assign rdTimeout = (state_q == READ) && timerExpired;
`else
    assign rdTimeout = 1'b0;
`endif

    always_comb begin
        respMsg        = '0;
        respMsg.rdResp = 1'b1;
        respMsg.half   = half_q;
        respMsg.addr   = addr_q;
        respMsg.data   = half_q ? {16'h0000, rdData_q[15:0]} : rdData_q;
    end

    assign regi_tready = (state_q == IDLE);
    assign rego_tvalid = (state_q == RESP);
    assign rego_tdata  = (state_q == RESP) ? iop2_pack(respMsg) : '0;
    assign reg_wr_stb  = (state_q == WRITE);
    assign reg_rd_stb  = (state_q == READ) && rdFirst_q;
    assign reg_addr    = addr_q[ADDR_W-1:0];
    assign reg_wr_data = half_q ? {16'h0000, wrData_q[15:0]} : wrData_q;
    assign reg_half    = half_q;

    assign unusedBits = ^{reqMsg.rdResp, reqMsg.rsvd, 32'(TIMEOUT)};

endmodule
